sdc_sector_server: RTL and testbench
====================================

Name: sdc_sector_server

Overview:
- Sits directly downstream of the data controller's SD interface. It consumes the per-device sector requests (sdc_rd/sdc_wr, sdc_lba, sdc_data_out) from IWM floppies and SCSI targets.
- Serves each request against a byte-stream raw-sector card port, with a per-device image base offset.
- Produces sdc_busy, sdc_done, sdc_data_in, sdc_data_en and sdc_addr back to the data controller.
- Handles one 512-byte sector per request. Requests that arrive while a transfer is in progress are queued in a pending vector.

Parameters:
DEVS, 4, number of requesters (2 floppies + SCSI_DEVS); bit i of req vectors = device i
TIMEOUT, 24'd8000000, clk cycles without card progress before abort (~0.5 s at 16 MHz)

Ports:
clk  in  1  16 MHz system clock
_systemReset  in  1  reset, asynchronous, active-low
req_rd  in  DEVS  read request pulses (connect sdc_rd)
req_wr  in  DEVS  write request pulses (connect sdc_wr)
req_lba  in  32  sector within image (connect sdc_lba); valid in the cycle a req bit is high
req_data  in  8  byte read from requester buffer at addr (connect sdc_data_out); 1-cycle read latency
img_base  in  32*DEVS  card sector where image i starts; bits [32i+31:32i]
busy  out  1  transfer in progress (connect sdc_busy)
done  out  1  1-cycle completion pulse (connect sdc_done)
err  out  1  qualifies done; 1 = transfer aborted
data_out  out  8  byte to requester buffer (connect sdc_data_in)
data_en  out  1  write strobe into requester buffer (connect sdc_data_en)
addr  out  9  buffer byte index (connect sdc_addr)
card_rd  out  1  1-cycle sector read command
card_wr  out  1  1-cycle sector write command
card_lba  out  32  card sector; held stable while busy
card_busy  in  1  card operation in progress
card_rd_data  in  8  read byte
card_rd_valid  in  1  read byte strobe
card_wr_data  out  8  write byte
card_wr_valid  out  1  write byte offered
card_wr_ready  in  1  write byte accepted when valid&ready
card_err  in  1  card failure; sampled while busy

Behaviour:
- Reset (async, any state): state=IDLE; pending=0; all outputs 0, including addr=0 and card_lba=0.
- pending_rd/pending_wr (DEVS each): set by req pulses. Both bits for the same device in one cycle → rd wins, wr dropped. A req for a device already pending overwrites its latched lba (per-device lba register).
- IDLE: if any pending bit is set, pick the lowest device index; on a tie, rd before wr. Clear that pending bit, set card_lba = img_base[dev] + lba[dev] (mod 2^32), go ISSUE. A req arriving in IDLE is served with ISSUE one cycle after the pulse.
- ISSUE: busy=1. Pulse card_rd or card_wr for one cycle. addr=0. Go RD_STREAM or WR_FETCH.
- RD_STREAM: on each card_rd_valid: data_out=card_rd_data and data_en=1 in the next cycle with the current addr; addr increments after that strobe. After byte 511 → FINISH.
- WR_FETCH: present addr, wait 1 cycle for req_data, go WR_OFFER.
- WR_OFFER: card_wr_data=req_data, card_wr_valid=1, held until card_wr_ready.
  - On handshake: byte 511 → FINISH; otherwise addr+1 → WR_FETCH.
  - Sustained throughput: 1 byte per 2 cycles.
- FINISH: wait card_busy==0, then done=1 and err=0 for one cycle, busy=0, addr=0 → IDLE. Back-to-back pending requests restart ISSUE the following cycle; busy goes low for at least one cycle between transfers.
- Abort: card_err=1, or watchdog reaching TIMEOUT, in any non-IDLE state.
  - Go FINISH_ERR: done=1, err=1 for one cycle, busy=0, card_wr_valid=0. The remaining bytes are not transferred.
  - The watchdog resets on ISSUE, on every data_en, and on every write handshake. It also resets in FINISH while card_busy changes.
- card_rd_valid outside RD_STREAM is ignored. card_wr_ready without valid is ignored.
- Requests for device i keep latching while device i's transfer is active; they are served afterwards, not merged.

Test Plan:
- Read dev2, lba=5, img_base[2]=0x1000: card_rd pulses once with card_lba=0x1005. Feed 512 bytes 0x00..0xFF twice → data_en fires 512 times with addr 0..511 and matching data, then one done with err=0, and busy returns to 0.
- Write dev0, lba=0, base=0: requester returns mem[addr]=addr[7:0]^0x5A with 1-cycle latency, and card_wr_ready toggles randomly. Card must receive exactly 512 bytes in order, then done.
- Simultaneous req_wr[3] and req_rd[1] while dev0's read is in progress → after dev0's done, dev1's read is served, then dev3's write. Two further done pulses, and busy drops between transfers.
- card_err asserted at byte 100 of a read → done=1 with err=1 next cycle and no data_en after the abort. Next pending request then proceeds normally.
- Card stalls with no rd_valid (TIMEOUT reduced to 1000) → err done at 1000 cycles after the last progress.
- _systemReset low mid-write at byte 300 → busy, card_wr_valid and done immediately 0 and pending cleared. A new request after release starts at addr 0.
- img_base=0xFFFFFFFF, lba=2 → card_lba=0x00000001 (wrap).

Source files
------------

// File: rtl/sdc_sector_server.sv
// Serves per-device 512-byte sector read/write requests from the data controller
// against a byte-stream raw-sector card port, adding a per-device image base offset.
module sdc_sector_server #(
  parameter int          DEVS    = 4,
  parameter logic [23:0] TIMEOUT = 24'd8000000
) (
  input  logic               clk,
  input  logic               _systemReset,
  input  logic [DEVS-1:0]    req_rd,
  input  logic [DEVS-1:0]    req_wr,
  input  logic [31:0]        req_lba,
  input  logic [7:0]         req_data,
  input  logic [32*DEVS-1:0] img_base,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [7:0]         data_out,
  output logic               data_en,
  output logic [8:0]         addr,
  output logic               card_rd,
  output logic               card_wr,
  output logic [31:0]        card_lba,
  input  logic               card_busy,
  input  logic [7:0]         card_rd_data,
  input  logic               card_rd_valid,
  output logic [7:0]         card_wr_data,
  output logic               card_wr_valid,
  input  logic               card_wr_ready,
  input  logic               card_err
);

  localparam int DW = (DEVS > 1) ? $clog2(DEVS) : 1;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_RD_STREAM  = 3'd2;
  localparam logic [2:0] S_WR_FETCH   = 3'd3;
  localparam logic [2:0] S_WR_OFFER   = 3'd4;
  localparam logic [2:0] S_FINISH     = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;
  localparam logic [2:0] S_FINISH_ERR = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [DEVS-1:0] pend_rd_q, pend_rd_d;
  logic [DEVS-1:0] pend_wr_q, pend_wr_d;
  logic [31:0]     lba_q [DEVS];
  logic [31:0]     card_lba_q, card_lba_d;
  logic            is_rd_q, is_rd_d;
  logic [8:0]      addr_q, addr_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_en_q, data_en_d;
  logic [23:0]     wd_q, wd_d;
  logic            card_busy_q;

  // A request seen in an arbitrating cycle competes immediately, so an idle
  // server issues the card command in the cycle right after the pulse.
  logic [DEVS-1:0] eff_rd, eff_wr;
  logic [31:0]     eff_lba [DEVS];
  logic            sel_valid, sel_rd;
  logic [DW-1:0]   sel_dev;

  assign eff_rd = pend_rd_q | req_rd;
  assign eff_wr = pend_wr_q | (req_wr & ~req_rd);

  always_comb begin
    for (int i = 0; i < DEVS; i++) begin
      eff_lba[i] = (req_rd[i] || req_wr[i]) ? req_lba : lba_q[i];
    end
  end

  // NOTE: every always_comb output gets a default before any branch so that no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_dev   = '0;
    sel_rd    = 1'b0;
    for (int i = DEVS - 1; i >= 0; i--) begin
      if (eff_rd[i] || eff_wr[i]) begin
        sel_valid = 1'b1;
        sel_dev   = DW'(i);
        sel_rd    = eff_rd[i];
      end
    end
  end

  logic in_xfer, arbitrating, abort;

  assign in_xfer = (state_q == S_ISSUE) || (state_q == S_RD_STREAM) ||
                   (state_q == S_WR_FETCH) || (state_q == S_WR_OFFER) ||
                   (state_q == S_FINISH);
  assign arbitrating = (state_q == S_IDLE) || (state_q == S_DONE) ||
                       (state_q == S_FINISH_ERR);
  assign abort = in_xfer && (card_err || (wd_q >= (TIMEOUT - 24'd1)));

  always_comb begin
    state_d    = state_q;
    pend_rd_d  = eff_rd;
    pend_wr_d  = eff_wr;
    card_lba_d = card_lba_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    data_en_d  = 1'b0;
    wd_d       = in_xfer ? wd_q + 24'd1 : 24'd0;

    if (abort) begin
      state_d = S_FINISH_ERR;
      addr_d  = 9'd0;
    end else if (arbitrating) begin
      state_d = S_IDLE;
      if (sel_valid) begin
        state_d    = S_ISSUE;
        is_rd_d    = sel_rd;
        card_lba_d = img_base[32*sel_dev +: 32] + eff_lba[sel_dev];
        if (sel_rd) pend_rd_d[sel_dev] = 1'b0;
        else        pend_wr_d[sel_dev] = 1'b0;
      end
    end else begin
      case (state_q)
        S_ISSUE: begin
          wd_d    = 24'd0;
          addr_d  = 9'd0;
          state_d = is_rd_q ? S_RD_STREAM : S_WR_FETCH;
        end
        S_RD_STREAM: begin
          if (data_en_q) begin
            addr_d = addr_q + 9'd1;
            wd_d   = 24'd0;
          end
          if (data_en_q && addr_q == 9'd511) begin
            state_d = S_FINISH;
          end else if (card_rd_valid) begin
            data_en_d  = 1'b1;
            data_out_d = card_rd_data;
          end
        end
        S_WR_FETCH: state_d = S_WR_OFFER;
        S_WR_OFFER: begin
          if (card_wr_ready) begin
            wd_d    = 24'd0;
            addr_d  = addr_q + 9'd1;
            state_d = (addr_q == 9'd511) ? S_FINISH : S_WR_FETCH;
          end
        end
        S_FINISH: begin
          if (card_busy != card_busy_q) wd_d = 24'd0;
          if (!card_busy) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset) begin
      state_q     <= S_IDLE;
      pend_rd_q   <= '0;
      pend_wr_q   <= '0;
      card_lba_q  <= '0;
      is_rd_q     <= 1'b0;
      addr_q      <= '0;
      data_out_q  <= '0;
      data_en_q   <= 1'b0;
      wd_q        <= '0;
      card_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      pend_wr_q   <= pend_wr_d;
      card_lba_q  <= card_lba_d;
      is_rd_q     <= is_rd_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      data_en_q   <= data_en_d;
      wd_q        <= wd_d;
      card_busy_q <= card_busy;
    end
  end

  // NOTE: the lba store is deliberately left without reset; an entry is only
  // read once its pending bit is set, which always rewrites it first.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEVS; i++) begin
      if (req_rd[i] || req_wr[i]) lba_q[i] <= req_lba;
    end
  end

  assign busy          = in_xfer;
  assign done          = (state_q == S_DONE) || (state_q == S_FINISH_ERR);
  assign err           = (state_q == S_FINISH_ERR);
  assign data_out      = data_out_q;
  assign data_en       = data_en_q;
  assign addr          = addr_q;
  assign card_rd       = (state_q == S_ISSUE) && is_rd_q;
  assign card_wr       = (state_q == S_ISSUE) && !is_rd_q;
  assign card_lba      = card_lba_q;
  assign card_wr_valid = (state_q == S_WR_OFFER);
  assign card_wr_data  = (state_q == S_WR_OFFER) ? req_data : 8'h00;

endmodule

// File: tb/tb_sdc_sector_server.sv
// Directed bench for sdc_sector_server: a card model streams read bytes and
// accepts write bytes, a negedge monitor tallies strobes and completions.
module tb_sdc_sector_server;

  localparam int          DEVS = 4;
  localparam logic [23:0] TMO  = 24'd1000;

  logic               clk = 1'b0;
  logic               _systemReset;
  logic [DEVS-1:0]    req_rd, req_wr;
  logic [31:0]        req_lba;
  logic [7:0]         req_data;
  logic [32*DEVS-1:0] img_base;
  logic               busy, done, err, data_en, card_rd, card_wr;
  logic [7:0]         data_out, card_rd_data, card_wr_data;
  logic [8:0]         addr;
  logic [31:0]        card_lba;
  logic               card_busy, card_rd_valid, card_wr_valid, card_wr_ready, card_err;

  sdc_sector_server #(.DEVS(DEVS), .TIMEOUT(TMO)) dut (
    .clk(clk), ._systemReset(_systemReset),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_data(req_data),
    .img_base(img_base), .busy(busy), .done(done), .err(err),
    .data_out(data_out), .data_en(data_en), .addr(addr),
    .card_rd(card_rd), .card_wr(card_wr), .card_lba(card_lba),
    .card_busy(card_busy), .card_rd_data(card_rd_data), .card_rd_valid(card_rd_valid),
    .card_wr_data(card_wr_data), .card_wr_valid(card_wr_valid),
    .card_wr_ready(card_wr_ready), .card_err(card_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, de_cnt = 0, de_idx = 0, de_bad = 0, wr_cnt = 0, wr_idx = 0, wr_bad = 0;
  int done_cnt = 0, card_rd_cnt = 0, card_wr_cnt = 0, busy_fall = 0;
  int err_cyc = 0, done_cyc = 0, cmd_cyc = 0;
  bit last_err = 1'b0, prev_busy = 1'b0;
  logic [31:0] log_lba [$];
  bit          log_rd  [$];

  // Requester buffer: registered read with one cycle of latency.
  always @(posedge clk) req_data <= addr[7:0] ^ 8'h5A;

  // Read data is byte k = k[7:0]; write data expected is k[7:0] ^ 0x5A.
  always @(negedge clk) begin
    cyc++;
    if (card_rd || card_wr) begin
      log_lba.push_back(card_lba);
      log_rd.push_back(card_rd);
      cmd_cyc = cyc;
    end
    if (card_rd) begin card_rd_cnt++; de_idx = 0; end
    if (card_wr) begin card_wr_cnt++; wr_idx = 0; end
    if (data_en) begin
      if (addr !== de_idx[8:0] || data_out !== de_idx[7:0]) de_bad++;
      de_idx++; de_cnt++;
    end
    if (card_wr_valid && card_wr_ready) begin
      if (card_wr_data !== (wr_idx[7:0] ^ 8'h5A) || addr !== wr_idx[8:0]) wr_bad++;
      wr_idx++; wr_cnt++;
    end
    if (card_err) err_cyc = cyc;
    if (done) begin done_cnt++; last_err = err; done_cyc = cyc; end
    if (prev_busy && !busy) busy_fall++;
    prev_busy = busy;
  end

  int rd_idx = 0, rd_err_at = -1;
  bit rd_active = 1'b0, rd_stall = 1'b0, rand_ready = 1'b0;

  always begin
    @(posedge clk); #1;
    card_rd_valid = 1'b0;
    card_err      = 1'b0;
    if (done || !_systemReset) rd_active = 1'b0;
    if (rd_active) begin
      if (rd_idx == rd_err_at) begin
        card_err = 1'b1; rd_active = 1'b0; rd_err_at = -1;
      end else if (!rd_stall) begin
        card_rd_valid = 1'b1;
        card_rd_data  = rd_idx[7:0];
        rd_idx++;
        if (rd_idx == 512) rd_active = 1'b0;
      end
    end
    if (card_rd) begin rd_active = 1'b1; rd_idx = 0; end
    card_wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_stats();
    de_cnt = 0; de_bad = 0; wr_cnt = 0; wr_bad = 0; done_cnt = 0;
    card_rd_cnt = 0; card_wr_cnt = 0; busy_fall = 0; last_err = 1'b0;
    log_lba.delete(); log_rd.delete();
  endtask

  task automatic pulse_req(input logic [DEVS-1:0] rd, input logic [DEVS-1:0] wr, input logic [31:0] lba);
    req_rd = rd; req_wr = wr; req_lba = lba;
    step();
    req_rd = '0; req_wr = '0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n = 0;
    while (done_cnt < target && n < budget) begin step(); n++; end
    ok = (done_cnt >= target);
  endtask

  task automatic wait_de(input int target, input int budget, output bit ok);
    int n = 0;
    while (de_cnt < target && n < budget) begin step(); n++; end
    ok = (de_cnt >= target);
  endtask

  task automatic wait_wr(input int target, input int budget, output bit ok);
    int n = 0;
    while (wr_cnt < target && n < budget) begin step(); n++; end
    ok = (wr_cnt >= target);
  endtask

  task automatic test_reset();
    _systemReset = 1'b0;
    req_rd = '0; req_wr = '0; req_lba = '0; img_base = '0; card_busy = 1'b0;
    card_rd_valid = 1'b0; card_rd_data = '0; card_err = 1'b0; card_wr_ready = 1'b0;
    repeat (3) step();
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL reset_status: busy=%b done=%b err=%b expected 0 0 0", busy, done, err); else pass_cnt++;
    total_cnt++; if (addr !== 9'd0 || card_lba !== 32'd0) $display("FAIL reset_addr: addr=%0d card_lba=%h expected 0 0", addr, card_lba); else pass_cnt++;
    total_cnt++; if (card_rd !== 1'b0 || card_wr !== 1'b0 || card_wr_valid !== 1'b0 || data_en !== 1'b0) $display("FAIL reset_strobes: rd=%b wr=%b wv=%b de=%b expected all 0", card_rd, card_wr, card_wr_valid, data_en); else pass_cnt++;
    _systemReset = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_read();
    bit ok;
    clear_stats();
    img_base[95:64] = 32'h0000_1000;
    card_busy = 1'b1;
    pulse_req(4'b0100, 4'b0000, 32'd5);
    total_cnt++; if (card_rd !== 1'b1) $display("FAIL read_issue_latency: card_rd=%b expected 1", card_rd); else pass_cnt++;
    total_cnt++; if (card_lba !== 32'h0000_1005) $display("FAIL read_card_lba: got %h expected 00001005", card_lba); else pass_cnt++;
    wait_de(512, 2000, ok);
    total_cnt++; if (!ok) $display("FAIL read_stream_timeout: data_en count %0d expected 512", de_cnt); else pass_cnt++;
    total_cnt++; if (de_bad !== 0) $display("FAIL read_data: %0d bad addr/data strobes expected 0", de_bad); else pass_cnt++;
    repeat (4) step();
    total_cnt++; if (done_cnt !== 0 || busy !== 1'b1) $display("FAIL read_wait_card_busy: done count %0d busy=%b expected 0 1", done_cnt, busy); else pass_cnt++;
    card_busy = 1'b0;
    wait_done(1, 50, ok);
    total_cnt++; if (!ok || last_err !== 1'b0) $display("FAIL read_done: done ok=%b err=%b expected 1 0", ok, last_err); else pass_cnt++;
    step();
    total_cnt++; if (busy !== 1'b0 || card_rd_cnt !== 1 || de_cnt !== 512) $display("FAIL read_end: busy=%b card_rd count %0d data_en count %0d expected 0 1 512", busy, card_rd_cnt, de_cnt); else pass_cnt++;
  endtask

  task automatic test_write();
    bit ok;
    clear_stats();
    rand_ready = 1'b1;
    img_base[31:0] = 32'd0;
    pulse_req(4'b0000, 4'b0001, 32'd0);
    total_cnt++; if (card_wr !== 1'b1 || card_lba !== 32'd0) $display("FAIL write_issue: card_wr=%b card_lba=%h expected 1 00000000", card_wr, card_lba); else pass_cnt++;
    wait_done(1, 8000, ok);
    total_cnt++; if (!ok || last_err !== 1'b0) $display("FAIL write_done: done ok=%b err=%b expected 1 0", ok, last_err); else pass_cnt++;
    total_cnt++; if (wr_cnt !== 512 || wr_bad !== 0) $display("FAIL write_bytes: %0d accepted %0d bad expected 512 0", wr_cnt, wr_bad); else pass_cnt++;
    rand_ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_stats();
    img_base[63:32]   = 32'h0000_0200;
    img_base[127:96]  = 32'h0000_0300;
    pulse_req(4'b0001, 4'b0000, 32'd7);
    wait_de(50, 500, ok);
    req_rd = 4'b0010; req_wr = 4'b1000; req_lba = 32'd9;
    step();
    req_rd = '0; req_wr = '0;
    wait_done(3, 6000, ok);
    total_cnt++; if (!ok || last_err !== 1'b0) $display("FAIL b2b_done: done count %0d err=%b expected 3 0", done_cnt, last_err); else pass_cnt++;
    total_cnt++; if (log_lba.size() !== 3) $display("FAIL b2b_cmd_count: %0d commands expected 3", log_lba.size()); else pass_cnt++;
    if (log_lba.size() == 3) begin
      total_cnt++; if (log_lba[0] !== 32'd7 || log_rd[0] !== 1'b1) $display("FAIL b2b_first: lba=%h rd=%b expected 00000007 1", log_lba[0], log_rd[0]); else pass_cnt++;
      total_cnt++; if (log_lba[1] !== 32'h209 || log_rd[1] !== 1'b1) $display("FAIL b2b_second: lba=%h rd=%b expected 00000209 1", log_lba[1], log_rd[1]); else pass_cnt++;
      total_cnt++; if (log_lba[2] !== 32'h309 || log_rd[2] !== 1'b0) $display("FAIL b2b_third: lba=%h rd=%b expected 00000309 0", log_lba[2], log_rd[2]); else pass_cnt++;
    end
    total_cnt++; if (busy_fall !== 3) $display("FAIL b2b_busy_gaps: busy fell %0d times expected 3", busy_fall); else pass_cnt++;
    total_cnt++; if (de_cnt !== 1024 || de_bad !== 0 || wr_cnt !== 512 || wr_bad !== 0) $display("FAIL b2b_data: de=%0d bad=%0d wr=%0d bad=%0d expected 1024 0 512 0", de_cnt, de_bad, wr_cnt, wr_bad); else pass_cnt++;
    step();
  endtask

  task automatic test_card_err();
    bit ok;
    clear_stats();
    rd_err_at = 100;
    pulse_req(4'b0001, 4'b0000, 32'd0);
    wait_de(20, 500, ok);
    pulse_req(4'b0010, 4'b0000, 32'd1);
    wait_done(1, 2000, ok);
    total_cnt++; if (!ok || last_err !== 1'b1) $display("FAIL err_done: done ok=%b err=%b expected 1 1", ok, last_err); else pass_cnt++;
    total_cnt++; if (done_cyc !== err_cyc + 1) $display("FAIL err_latency: done %0d cycles after card_err expected 1", done_cyc - err_cyc); else pass_cnt++;
    total_cnt++; if (de_cnt !== 100) $display("FAIL err_bytes: %0d data_en before abort expected 100", de_cnt); else pass_cnt++;
    wait_done(2, 2000, ok);
    total_cnt++; if (!ok || last_err !== 1'b0) $display("FAIL err_next_done: done count %0d err=%b expected 2 0", done_cnt, last_err); else pass_cnt++;
    total_cnt++; if (de_cnt !== 612 || de_bad !== 0) $display("FAIL err_next_data: de=%0d bad=%0d expected 612 0", de_cnt, de_bad); else pass_cnt++;
    if (log_lba.size() == 2) begin
      total_cnt++; if (log_lba[1] !== 32'h201) $display("FAIL err_next_lba: got %h expected 00000201", log_lba[1]); else pass_cnt++;
    end else begin
      total_cnt++; $display("FAIL err_cmd_count: %0d commands expected 2", log_lba.size());
    end
    step();
  endtask

  task automatic test_timeout();
    bit ok;
    clear_stats();
    rd_stall = 1'b1;
    pulse_req(4'b0001, 4'b0000, 32'd3);
    wait_done(1, 3000, ok);
    total_cnt++; if (!ok || last_err !== 1'b1) $display("FAIL timeout_done: done ok=%b err=%b expected 1 1", ok, last_err); else pass_cnt++;
    total_cnt++; if (done_cyc - cmd_cyc < int'(TMO) || done_cyc - cmd_cyc > int'(TMO) + 1) $display("FAIL timeout_cycles: done %0d cycles after issue expected %0d..%0d", done_cyc - cmd_cyc, TMO, TMO + 1); else pass_cnt++;
    total_cnt++; if (de_cnt !== 0) $display("FAIL timeout_bytes: %0d data_en expected 0", de_cnt); else pass_cnt++;
    rd_stall = 1'b0;
    step();
  endtask

  task automatic test_same_dev();
    bit ok;
    clear_stats();
    pulse_req(4'b0100, 4'b0100, 32'd0);
    wait_done(1, 2000, ok);
    repeat (20) step();
    total_cnt++; if (done_cnt !== 1 || card_rd_cnt !== 1 || card_wr_cnt !== 0) $display("FAIL same_dev_rd_wins: done=%0d rd=%0d wr=%0d expected 1 1 0", done_cnt, card_rd_cnt, card_wr_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit ok;
    clear_stats();
    img_base[127:96] = 32'hFFFF_FFFF;
    pulse_req(4'b1000, 4'b0000, 32'd2);
    total_cnt++; if (card_lba !== 32'h0000_0001 || card_rd !== 1'b1) $display("FAIL wrap_lba: card_lba=%h card_rd=%b expected 00000001 1", card_lba, card_rd); else pass_cnt++;
    wait_done(1, 2000, ok);
    total_cnt++; if (!ok || last_err !== 1'b0) $display("FAIL wrap_done: done ok=%b err=%b expected 1 0", ok, last_err); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    clear_stats();
    pulse_req(4'b0000, 4'b0001, 32'd0);
    wait_wr(300, 2000, ok);
    pulse_req(4'b0010, 4'b0000, 32'd4);
    _systemReset = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || card_wr_valid !== 1'b0 || done !== 1'b0 || addr !== 9'd0) $display("FAIL midreset_outputs: busy=%b wv=%b done=%b addr=%0d expected 0 0 0 0", busy, card_wr_valid, done, addr); else pass_cnt++;
    repeat (3) step();
    _systemReset = 1'b1;
    clear_stats();
    repeat (20) step();
    total_cnt++; if (busy !== 1'b0 || card_rd_cnt + card_wr_cnt !== 0) $display("FAIL midreset_pending: busy=%b commands=%0d expected 0 0", busy, card_rd_cnt + card_wr_cnt); else pass_cnt++;
    pulse_req(4'b0000, 4'b0100, 32'd0);
    total_cnt++; if (card_wr !== 1'b1 || addr !== 9'd0 || card_lba !== 32'h1000) $display("FAIL midreset_restart: wr=%b addr=%0d lba=%h expected 1 0 00001000", card_wr, addr, card_lba); else pass_cnt++;
    wait_done(1, 3000, ok);
    total_cnt++; if (!ok || last_err !== 1'b0 || wr_cnt !== 512 || wr_bad !== 0) $display("FAIL midreset_write: ok=%b err=%b wr=%0d bad=%0d expected 1 0 512 0", ok, last_err, wr_cnt, wr_bad); else pass_cnt++;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench hang");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_card_err();
    test_timeout();
    test_same_dev();
    test_wrap();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
